// File: rtl/lvds_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : lvds_tx_serializer
// Purpose  : Parallel-to-serial transmitter for the LVDS output link. Requests
//            words from the upstream data controller with a one-cycle strobe
//            (dr) and shifts each word out MSB-first on tx, together with a
//            forwarded bit clock (txclk) running at clk/CLK_DIV, 50% duty.
//
// Parameters:
//   CLK_DIV : clk cycles per serial bit (even, >= 2). Kept first so it can be
//             overridden positionally.
//   WIDTH   : bits per word.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active low
//   oe      in   output enable / stream request
//   data    in   word to send, sampled on the edge that ends a dr-high cycle
//   dr      out  data request, registered one-cycle pulse
//   txclk   out  forwarded serial bit clock
//   tx      out  serial data, MSB first
//
// Build option:
//   LVDS_TX_PARITY_EN : when defined, an odd-parity bit follows the LSB of
//                       every word, making a frame WIDTH+1 bits long.
//
// Revision : 1.0 - initial release
// ============================================================================
module lvds_tx_serializer #(
  parameter int CLK_DIV = 16,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic [WIDTH-1:0] data,
  output logic             dr,
  output logic             txclk,
  output logic             tx
);

  // --------------------------------------------------------------------------
  // Frame geometry
  // --------------------------------------------------------------------------
`ifdef LVDS_TX_PARITY_EN
  localparam int c_FRAME = WIDTH + 1;
`else
  localparam int c_FRAME = WIDTH;
`endif

  localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_IDX_W = (c_FRAME > 1) ? $clog2(c_FRAME) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_PRE  = c_CNT_W'(CLK_DIV - 2);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLK_DIV / 2);
  localparam logic [c_IDX_W-1:0] c_IDX_TOP  = c_IDX_W'(c_FRAME - 1);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic [c_FRAME-1:0]   r_sh;
  logic [c_FRAME-1:0]   w_sh_nxt;
  logic                 r_dr;
  logic                 w_dr_nxt;

  // Frame as it is loaded into the shift register.
  logic [c_FRAME-1:0]   w_frame;

`ifdef LVDS_TX_PARITY_EN
  // Odd parity: the ones count over word plus parity bit is odd.
  assign w_frame = {data, ~(^data)};
`else
  assign w_frame = data;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_dr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_sh    <= w_sh_nxt;
      r_dr    <= w_dr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_dr_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (oe) begin
          // dr is registered, so it is raised on the edge entering REQ and
          // is high for exactly the REQ cycle.
          w_state_nxt = S_REQ;
          w_dr_nxt    = 1'b1;
        end
      end

      S_REQ: begin
        w_sh_nxt    = w_frame;
        w_idx_nxt   = c_IDX_TOP;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SHIFT;
      end

      S_SHIFT: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx != '0) begin
            w_sh_nxt  = r_sh << 1;
            w_idx_nxt = r_idx - 1'b1;
          end else if (r_dr) begin
            // A request went out during this final cycle, so the source is
            // presenting the next word now: reload and keep streaming.
            // Keying on r_dr (not on oe now) guarantees a word is only
            // loaded when it was actually requested.
            w_sh_nxt  = w_frame;
            w_idx_nxt = c_IDX_TOP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          // Raise dr one edge early so the registered pulse covers the last
          // cycle of the last bit.
          if ((r_idx == '0) && (r_cnt == c_CNT_PRE) && oe) begin
            w_dr_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // tx and txclk decode straight from registers, so they only move on clk
  // edges and drop to 0 together with the asynchronous reset. tx follows the
  // shift register MSB, which only changes when cnt returns to 0, i.e. on the
  // txclk falling edge; the receiver samples on the rising edge.
  always_comb begin
    tx    = 1'b0;
    txclk = 1'b0;
    if (r_state == S_SHIFT) begin
      tx    = r_sh[c_FRAME-1];
      txclk = (r_cnt >= c_CNT_HALF);
    end
  end

  assign dr = r_dr;

endmodule
`default_nettype wire

// File: tb/tb_lvds_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_tx_serializer
// Purpose  : Self-checking bench for lvds_tx_serializer. A behavioural source
//            answers every dr with a word; a behavioural receiver samples tx
//            on txclk rising edges and rebuilds frames, which are compared
//            against the words handed out. Timing rules (dr spacing, dr pulse
//            width, txclk duty, tx transition points, idle levels) are
//            checked independently.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_tx_serializer;

  localparam int CLK_DIV = 16;
  localparam int WIDTH   = 8;
`ifdef LVDS_TX_PARITY_EN
  localparam int FRAME   = WIDTH + 1;
`else
  localparam int FRAME   = WIDTH;
`endif
  localparam int WORD_CYC = FRAME * CLK_DIV;
  localparam int HALF     = CLK_DIV / 2;

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             oe   = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             dr;
  logic             txclk;
  logic             tx;

  lvds_tx_serializer #(
    .CLK_DIV (CLK_DIV),
    .WIDTH   (WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .oe    (oe),
    .data  (data),
    .dr    (dr),
    .txclk (txclk),
    .tx    (tx)
  );

  always #10 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] exp_q[$];
  int               cyc          = 0;
  int               dr_count     = 0;
  int               rx_count     = 0;
  int               last_dr_cyc  = 0;
  bit               have_last_dr = 1'b0;
  bit               oe_cont      = 1'b0;
  bit               prev_dr      = 1'b0;
  bit               prev_txclk   = 1'b0;
  bit               prev_tx      = 1'b0;
  int               hi_run       = 0;
  int               lo_run       = 1000;
  logic [FRAME-1:0] rx_bits      = '0;
  logic [FRAME-1:0] last_rx      = '0;
  int               rx_n         = 0;
  int               src_mode     = 0;  // 0: increment, 1: random, 2: hold

  // Expected serial frame for a word: the word MSB-first, plus an odd-parity
  // bit when parity is enabled.
  function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef LVDS_TX_PARITY_EN
    int ones;
    ones = $countones(w);
    frame_of = {w, ((ones % 2) == 0) ? 1'b1 : 1'b0};
`else
    frame_of = w;
`endif
  endfunction

  task automatic reset_model();
    exp_q.delete();
    rx_n         = 0;
    have_last_dr = 1'b0;
    oe_cont      = 1'b0;
    prev_dr      = 1'b0;
    prev_txclk   = 1'b0;
    prev_tx      = 1'b0;
    hi_run       = 0;
    lo_run       = 1000;
  endtask

  // Observes one sample (taken 1 ns after a rising edge) and acts as both the
  // upstream source and the link receiver.
  task automatic monitor();
    logic [WIDTH-1:0] w;
    cyc++;
    if (!oe) oe_cont = 1'b0;

    if (dr) begin
      check_eq("dr_single_cycle", prev_dr, 0);
      if (have_last_dr) begin
        if (oe_cont) check_eq("dr_period", cyc - last_dr_cyc, WORD_CYC);
        else         check_eq("dr_gap_min", (cyc - last_dr_cyc) >= WORD_CYC, 1);
      end
      exp_q.push_back(data);
      dr_count++;
      last_dr_cyc  = cyc;
      have_last_dr = 1'b1;
      oe_cont      = 1'b1;
    end

    if (tx !== prev_tx)
      check_eq("tx_change_at_bit_edge", (prev_txclk && !txclk) || prev_dr, 1);

    if (txclk && !prev_txclk) begin
      check_eq("txclk_low_min", lo_run >= HALF, 1);
      rx_bits = {rx_bits[FRAME-2:0], tx};
      rx_n++;
      if (rx_n == FRAME) begin
        rx_n = 0;
        rx_count++;
        last_rx = rx_bits;
        check_eq("rx_word_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check_eq("rx_word", rx_bits, frame_of(w));
        end
      end
    end
    if (!txclk && prev_txclk) check_eq("txclk_high_len", hi_run, HALF);

    if (txclk) hi_run = prev_txclk ? hi_run + 1 : 1;
    else       lo_run = prev_txclk ? 1 : lo_run + 1;

    // Source: the word was latched on the edge that ended dr, so present the
    // next one now.
    if (prev_dr && !dr) begin
      case (src_mode)
        0:       data = data + 1'b1;
        1:       data = WIDTH'($urandom);
        default: data = data;
      endcase
    end

    prev_dr    = dr;
    prev_txclk = txclk;
    prev_tx    = tx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_dr"},    dr,    0);
    check_eq({tag, "_txclk"}, txclk, 0);
    check_eq({tag, "_tx"},    tx,    0);
  endtask

  task automatic wait_dr(input int max_cyc);
    int start;
    int n;
    start = dr_count;
    n     = 0;
    while (dr_count == start && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("dr_within_bound", dr_count != start, 1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int base;
    int guard;

    // Reset held with oe low.
    rst = 1'b0;
    repeat (5) begin
      step();
      check_idle("reset");
    end
    rst = 1'b1;
    repeat (5) begin
      step();
      check_idle("idle_oe_low");
    end

    // Incrementing stream 0,1,2,... of 100 words.
    src_mode = 0;
    data     = '0;
    oe       = 1'b1;
    step();
    check_eq("first_dr_latency", dr, 1);
    guard = 0;
    while (dr_count < 100 && guard < 100 * WORD_CYC + 100) begin
      step();
      guard++;
    end
    check_eq("stream_100_words", dr_count >= 100, 1);

    // Random data with random oe toggling, including mid-word drops.
    src_mode = 1;
    for (int s = 0; s < 30; s++) begin
      oe = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 400)) step();
    end
    oe = 1'b0;
    repeat (WORD_CYC + 20) step();
    check_eq("drain_queue_empty", exp_q.size(), 0);
    check_eq("drain_rx_equals_dr", rx_count, dr_count);
    check_idle("drain_idle");

    // oe dropped midway through 0xA5: word completes, no further request.
    src_mode = 2;
    data     = 8'hA5;
    base     = dr_count;
    oe       = 1'b1;
    wait_dr(8);
    repeat (3 * CLK_DIV + 4) step();
    oe = 1'b0;
    repeat (WORD_CYC + 20) step();
    check_eq("a5_single_dr", dr_count - base, 1);
    check_eq("a5_queue_empty", exp_q.size(), 0);
    check_eq("a5_bits", last_rx, frame_of(8'hA5));
    check_idle("a5_idle");

    // Asynchronous reset during bit 3 of a word.
    src_mode = 0;
    data     = 8'h3C;
    oe       = 1'b1;
    wait_dr(8);
    repeat (3 * CLK_DIV + 5) step();
    rst = 1'b0;
    #1;
    check_idle("async_reset");
    reset_model();
    repeat (3) begin
      step();
      check_idle("in_reset");
    end
    rst = 1'b1;
    step();
    check_eq("dr_after_reset", dr, 1);
    wait_dr(WORD_CYC + 8);
    wait_dr(WORD_CYC + 8);
    oe = 1'b0;
    repeat (WORD_CYC + 20) step();
    check_eq("post_reset_queue_empty", exp_q.size(), 0);
    check_idle("post_reset_idle");

`ifdef LVDS_TX_PARITY_EN
    // Parity frame for 0x03 is 0000_0011_1.
    src_mode = 2;
    data     = 8'h03;
    oe       = 1'b1;
    wait_dr(8);
    oe = 1'b0;
    repeat (WORD_CYC + 20) step();
    check_eq("parity_03_bits", last_rx, 9'b0000_0011_1);
    check_idle("parity_idle");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lvds_tx_serializer.md
Name: lvds_tx_serializer

Overview:
- Parallel-to-serial transmitter for the LVDS output link.
- Takes 8-bit words from an upstream source using a one-cycle data-request strobe (dr).
- Shifts each word out MSB-first on tx, with a forwarded bit clock on txclk running at clk/CLK_DIV.
- Sits between the data controller (word source) and the LVDS output buffers.

Parameters:
- CLK_DIV, 16, clk cycles per serial bit. Must be even and >= 2. Must be the first parameter, because it is overridden positionally.
- WIDTH, 8, bits per word. The shift register and the data port are WIDTH bits wide.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- oe  in  1  output enable / stream request.
- data  in  WIDTH  word to send; sampled on the clk edge that ends a dr-high cycle.
- dr  out  1  data request; one-cycle pulse, registered.
- txclk  out  1  forwarded serial bit clock.
- tx  out  1  serial data, MSB first.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; bit counter, bit index and shift register all 0.
  - Outputs: dr=0, txclk=0, tx=0.
- States: IDLE, REQ, SHIFT.
- IDLE:
  - txclk=0, tx=0, counter held at 0.
  - If oe=1 at a clk edge, go to REQ.
- REQ (exactly one clk cycle):
  - dr=1.
  - On the following edge: shift_reg<=data, bit_idx<=WIDTH-1, cnt<=0, go to SHIFT.
- SHIFT:
  - cnt runs 0..CLK_DIV-1 within each bit period.
  - txclk=0 while cnt<CLK_DIV/2, txclk=1 otherwise, giving a 50% duty cycle.
  - tx=shift_reg[WIDTH-1] for the whole bit period. tx changes only at cnt=0 (txclk falling edge), so the receiver samples on the txclk rising edge.
  - At cnt=CLK_DIV-1 with bit_idx>0: shift left by 1, bit_idx-=1, cnt<=0.
  - Last bit (bit_idx=0):
    - dr=1 during the cycle where cnt=CLK_DIV-1, if oe=1.
    - At the end of that cycle, load data, reset bit_idx and cnt, and stay in SHIFT. Words therefore stream back-to-back with no gap.
    - If oe=0 at that point: no dr, go to IDLE.
- Timing:
  - Each word occupies exactly WIDTH*CLK_DIV clk cycles (128 at defaults).
  - In continuous streaming, dr pulses are exactly WIDTH*CLK_DIV cycles apart.
  - First tx bit appears 2 clk cycles after oe is sampled high in IDLE.
- oe dropping mid-word: the current word completes, no new request is made, then the block returns to IDLE.
- oe rising again while the last bit is being sent: no REQ state; dr is issued at the last-bit boundary.
- dr is registered and is never high for two consecutive cycles.
- Upstream may change data on the cycle after dr. The DUT has already latched it.
- Reset mid-word aborts immediately. Outputs go to reset values on the same clock-independent assertion.

Optional Feature:
- Macro LVDS_TX_PARITY_EN.
- When defined:
  - One odd-parity bit is appended after the LSB of each word. Parity is computed over the latched word so that the ones count including parity is odd.
  - Word period becomes (WIDTH+1)*CLK_DIV cycles.
  - dr is issued in the last cycle of the parity bit.
- When undefined: the frame is WIDTH bits, exactly as described above.

Test Plan:
- Reset held low for 5 clks with oe=0 -> dr=0, txclk=0, tx=0 throughout. After rst=1 with oe=0, outputs remain 0.
- Set rst=1 and oe=1 together; source increments data on every dr (0,1,2,...) -> first dr 1 cycle after oe is sampled. tx carries 0x00, 0x01, 0x02... MSB first. Word 0x01 shows tx high only in the 8th bit period.
- Continuous stream at CLK_DIV=16 with 50 MHz clk -> txclk period 320 ns at 50% duty. Consecutive dr pulses are 128 clks (2.56 us) apart. 100 dr pulses are received with no gaps or lost words.
- Drop oe to 0 midway through word 0xA5 -> tx completes 1,0,1,0,0,1,0,1, no further dr, then tx=0 and txclk=0 in IDLE.
- Assert rst=0 during bit 3 of a word -> tx=0, txclk=0, dr=0 immediately. After release with oe=1, the first dr again follows 1 cycle after oe is sampled.
- With LVDS_TX_PARITY_EN and data=0x03 -> 9th bit=1 (odd parity). Frame length is 144 clks.
